// File: rtl/mini6502_pkg.sv
// Shared types and constants for the mini6502 core: FSM states, addressing modes,
// register-write targets, opcodes and fixed addresses.
package mini6502_pkg;

    typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH, OP1, OP2, EXEC, HALT} state_t;
    typedef enum logic [2:0] {MODE_IMP, MODE_IMM, MODE_ZP, MODE_ABS, MODE_JMP} amode_t;
    typedef enum logic [2:0] {DST_NONE, DST_A, DST_X, DST_Y, DST_S} dst_t;

    localparam logic [15:0] RESET_VEC = 16'hFFFC;
    localparam logic [15:0] ROM_BASE  = 16'hF000;
    localparam logic [7:0]  S_RESET   = 8'hFD;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_STX_ZP  = 8'h86;
    localparam logic [7:0] OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TAY     = 8'hA8;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_TYA     = 8'h98;
    localparam logic [7:0] OP_TSX     = 8'hBA;
    localparam logic [7:0] OP_TXS     = 8'h9A;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_DEY     = 8'h88;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_BRK     = 8'h00;

    // Anything not listed as an operand-bearing opcode is a 1-byte implied op.
    function automatic amode_t op_mode(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: op_mode = MODE_IMM;
            OP_STA_ZP, OP_STX_ZP, OP_STY_ZP:    op_mode = MODE_ZP;
            OP_STA_ABS, OP_STX_ABS, OP_STY_ABS: op_mode = MODE_ABS;
            OP_JMP_ABS:                         op_mode = MODE_JMP;
            OP_NOP, OP_BRK:                     op_mode = MODE_IMP;
            default:                            op_mode = MODE_IMP;
        endcase
    endfunction

endpackage

// File: rtl/mini6502_mem.sv
// On-chip memory: ROM at 0xF000-0xFFFF (read-only), RAM at 0x0000-0x01FF,
// everything else reads 8'hFF. Combinational read, write on rising clock edge.
module mini6502_mem
    import mini6502_pkg::*;
#(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 9
) (
    input  logic        i_clk,
    input  logic [15:0] i_addr,
    input  logic        i_we,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata
);

    logic [7:0] ROM [0:(1 << ROM_AW) - 1];
    logic [7:0] RAM [0:(1 << RAM_AW) - 1];

    logic w_is_rom;
    logic w_is_ram;

    assign w_is_rom = (i_addr[15:12] == ROM_BASE[15:12]);
    assign w_is_ram = (i_addr < 16'(1 << RAM_AW));

    always_comb begin
        if (w_is_rom)
            o_rdata = ROM[i_addr[ROM_AW-1:0]];
        else if (w_is_ram)
            o_rdata = RAM[i_addr[RAM_AW-1:0]];
        else
            o_rdata = 8'hFF;
    end

    always_ff @(posedge i_clk) begin
        if (i_we && w_is_ram)
            RAM[i_addr[RAM_AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mini6502_top.sv
// mini6502_top: multi-cycle 6502-subset core plus on-chip memory (instance mem).
// Define BRK_HALT_EN to make opcode 00 halt the core until reset; otherwise it is a NOP.
module mini6502_top
    import mini6502_pkg::*;
#(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 9
) (
    input logic ph1,
    input logic resetb
);

    state_t      r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_ir, r_op1, r_op2;
    logic [7:0]  r_a, r_x, r_y, r_s;
    logic        r_c, r_n, r_z;

    logic [15:0] w_addr;
    logic [7:0]  w_rdata, w_wdata, w_ld_val;
    logic        w_we, w_is_store, w_ld_fire, w_brk;
    amode_t      w_mode;
    dst_t        w_ld_dst;

    mini6502_mem #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) mem (
        .i_clk   (ph1),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_mode = op_mode(r_ir);

`ifdef BRK_HALT_EN
    assign w_brk = (w_rdata == OP_BRK);
`else
    assign w_brk = 1'b0;
`endif

    always_comb begin
        w_addr = r_pc;
        case (r_state)
            VEC_LO:  w_addr = RESET_VEC;
            VEC_HI:  w_addr = RESET_VEC + 16'd1;
            EXEC:    w_addr = (w_mode == MODE_ZP) ? {8'h00, r_op1} : {r_op2, r_op1};
            default: ;
        endcase
    end

    always_comb begin
        w_is_store = 1'b1;
        w_wdata    = r_a;
        case (r_ir)
            OP_STA_ZP, OP_STA_ABS: w_wdata = r_a;
            OP_STX_ZP, OP_STX_ABS: w_wdata = r_x;
            OP_STY_ZP, OP_STY_ABS: w_wdata = r_y;
            default:               w_is_store = 1'b0;
        endcase
    end

    // Gating with resetb makes a reset in the EXEC cycle abort the store.
    assign w_we = (r_state == EXEC) && w_is_store && resetb;

    // Immediate loads complete in OP1; every other register op completes in EXEC.
    always_comb begin
        w_ld_dst = DST_NONE;
        w_ld_val = '0;
        case (r_ir)
            OP_LDA_IMM: begin w_ld_dst = DST_A; w_ld_val = w_rdata;      end
            OP_LDX_IMM: begin w_ld_dst = DST_X; w_ld_val = w_rdata;      end
            OP_LDY_IMM: begin w_ld_dst = DST_Y; w_ld_val = w_rdata;      end
            OP_TAX:     begin w_ld_dst = DST_X; w_ld_val = r_a;          end
            OP_TAY:     begin w_ld_dst = DST_Y; w_ld_val = r_a;          end
            OP_TXA:     begin w_ld_dst = DST_A; w_ld_val = r_x;          end
            OP_TYA:     begin w_ld_dst = DST_A; w_ld_val = r_y;          end
            OP_TSX:     begin w_ld_dst = DST_X; w_ld_val = r_s;          end
            OP_TXS:     begin w_ld_dst = DST_S; w_ld_val = r_x;          end
            OP_INX:     begin w_ld_dst = DST_X; w_ld_val = r_x + 8'd1;   end
            OP_INY:     begin w_ld_dst = DST_Y; w_ld_val = r_y + 8'd1;   end
            OP_DEX:     begin w_ld_dst = DST_X; w_ld_val = r_x - 8'd1;   end
            OP_DEY:     begin w_ld_dst = DST_Y; w_ld_val = r_y - 8'd1;   end
            default:    ;
        endcase
    end

    assign w_ld_fire = (r_state == EXEC) || ((r_state == OP1) && (w_mode == MODE_IMM));

    always_ff @(posedge ph1) begin
        if (!resetb) begin
            r_state <= VEC_LO;
            r_pc    <= '0;
            r_ir    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_a     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= S_RESET;
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            if (w_ld_fire) begin
                case (w_ld_dst)
                    DST_A:   r_a <= w_ld_val;
                    DST_X:   r_x <= w_ld_val;
                    DST_Y:   r_y <= w_ld_val;
                    DST_S:   r_s <= w_ld_val;
                    default: ;
                endcase
                if ((w_ld_dst != DST_NONE) && (w_ld_dst != DST_S)) begin
                    r_n <= w_ld_val[7];
                    r_z <= (w_ld_val == 8'h00);
                end
            end

            case (r_state)
                VEC_LO: begin
                    r_pc[7:0] <= w_rdata;
                    r_state   <= VEC_HI;
                end
                VEC_HI: begin
                    r_pc[15:8] <= w_rdata;
                    r_state    <= FETCH;
                end
                FETCH: begin
                    r_ir <= w_rdata;
                    r_pc <= r_pc + 16'd1;
                    if (op_mode(w_rdata) == MODE_IMP)
                        r_state <= w_brk ? HALT : EXEC;
                    else
                        r_state <= OP1;
                end
                OP1: begin
                    r_op1 <= w_rdata;
                    r_pc  <= r_pc + 16'd1;
                    case (w_mode)
                        MODE_IMM: r_state <= FETCH;
                        MODE_ZP:  r_state <= EXEC;
                        default:  r_state <= OP2;
                    endcase
                end
                OP2: begin
                    r_op2 <= w_rdata;
                    if (w_mode == MODE_JMP) begin
                        r_pc    <= {w_rdata, r_op1};
                        r_state <= FETCH;
                    end else begin
                        r_pc    <= r_pc + 16'd1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_ir == OP_CLC)
                        r_c <= 1'b0;
                    else if (r_ir == OP_SEC)
                        r_c <= 1'b1;
                    r_state <= FETCH;
                end
                HALT:    r_state <= HALT;
                default: r_state <= VEC_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_mini6502_top.sv
// Bench for mini6502_top: directed programs with literal expectations, then random
// programs checked against an instruction-level model. Honours BRK_HALT_EN.
module tb_mini6502_top;
    import mini6502_pkg::*;

    logic ph1    = 1'b0;
    logic resetb = 1'b0;

    int checks   = 0;
    int failures = 0;

    mini6502_top #(.ROM_AW(12), .RAM_AW(9)) dut (
        .ph1    (ph1),
        .resetb (resetb)
    );

    always #5 ph1 = ~ph1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- program loading ----------------
    logic [7:0]  mrom [0:4095];
    int          wp;
    logic [15:0] term;
    logic        model_on = 1'b0;

    logic [7:0] ops [0:22] = '{8'hA9, 8'hA2, 8'hA0, 8'h85, 8'h86, 8'h84, 8'h8D, 8'h8E,
                               8'h8C, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hBA, 8'h9A, 8'hE8,
                               8'hC8, 8'hCA, 8'h88, 8'h18, 8'h38, 8'hEA, 8'h4C};

    function automatic bit listed(input logic [7:0] op);
        for (int i = 0; i < 23; i++)
            if (ops[i] == op) return 1'b1;
        return op == 8'h00;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 4096; i++) begin
            dut.mem.ROM[i] = 8'hEA;
            mrom[i] = 8'hEA;
        end
        dut.mem.ROM[4092] = 8'h00; mrom[4092] = 8'h00;
        dut.mem.ROM[4093] = 8'hF0; mrom[4093] = 8'hF0;
        wp = 0;
    endtask

    task automatic put(input logic [7:0] b);
        dut.mem.ROM[wp] = b;
        mrom[wp] = b;
        wp++;
    endtask

    task automatic put_jmp_self();
        logic [15:0] a;
        a = 16'hF000 + 16'(wp);
        term = a;
        put(8'h4C); put(a[7:0]); put(a[15:8]);
    endtask

    task automatic load(input logic [7:0] q[$]);
        fill_rom();
        foreach (q[i]) put(q[i]);
        put_jmp_self();
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge ph1);
        #2;
    endtask

    task automatic reset_cpu(input logic en_model);
        @(posedge ph1);
        #1 resetb = 1'b0;
        model_on = en_model;
        repeat (2) @(posedge ph1);
        #2;
        chk("rst_regs", {dut.r_a, dut.r_x, dut.r_y, dut.r_s, dut.r_c, dut.r_n, dut.r_z},
            {8'h00, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0, 1'b0});
        chk("rst_state", 64'(dut.r_state), 64'(VEC_LO));
        @(posedge ph1);
        #1 resetb = 1'b1;
    endtask

    // ---------------- instruction-level model ----------------
    logic [15:0] m_pc;
    logic [7:0]  m_a, m_x, m_y, m_s;
    logic        m_c, m_n, m_z;
    int          cnt, next_fetch;
    logic        pend_ram, pend_rom;
    logic [15:0] pend_addr;
    logic [7:0]  pend_val;

    function automatic logic [7:0] rd(input logic [15:0] a);
        if (a[15:12] == 4'hF) return mrom[a[11:0]];
        return 8'hFF;
    endfunction

    task automatic setnz(input logic [7:0] v);
        m_n = v[7];
        m_z = (v == 8'h00);
    endtask

    task automatic model_step();
        logic [7:0]  op, b1, b2, sv;
        logic [15:0] sa;
        logic        sv_en;
        int          len, cy;
        op = rd(m_pc); b1 = rd(m_pc + 16'd1); b2 = rd(m_pc + 16'd2);
        len = 1; cy = 2; sv_en = 1'b0; sv = 8'h00; sa = 16'h0000;
        case (op)
            8'hA9: begin m_a = b1; setnz(m_a); len = 2; end
            8'hA2: begin m_x = b1; setnz(m_x); len = 2; end
            8'hA0: begin m_y = b1; setnz(m_y); len = 2; end
            8'h85: begin sv_en = 1'b1; sv = m_a; sa = {8'h00, b1}; len = 2; cy = 3; end
            8'h86: begin sv_en = 1'b1; sv = m_x; sa = {8'h00, b1}; len = 2; cy = 3; end
            8'h84: begin sv_en = 1'b1; sv = m_y; sa = {8'h00, b1}; len = 2; cy = 3; end
            8'h8D: begin sv_en = 1'b1; sv = m_a; sa = {b2, b1}; len = 3; cy = 4; end
            8'h8E: begin sv_en = 1'b1; sv = m_x; sa = {b2, b1}; len = 3; cy = 4; end
            8'h8C: begin sv_en = 1'b1; sv = m_y; sa = {b2, b1}; len = 3; cy = 4; end
            8'hAA: begin m_x = m_a; setnz(m_x); end
            8'hA8: begin m_y = m_a; setnz(m_y); end
            8'h8A: begin m_a = m_x; setnz(m_a); end
            8'h98: begin m_a = m_y; setnz(m_a); end
            8'hBA: begin m_x = m_s; setnz(m_x); end
            8'h9A: m_s = m_x;
            8'hE8: begin m_x = m_x + 8'd1; setnz(m_x); end
            8'hC8: begin m_y = m_y + 8'd1; setnz(m_y); end
            8'hCA: begin m_x = m_x - 8'd1; setnz(m_x); end
            8'h88: begin m_y = m_y - 8'd1; setnz(m_y); end
            8'h18: m_c = 1'b0;
            8'h38: m_c = 1'b1;
            8'h4C: begin m_pc = {b2, b1}; len = 0; cy = 3; end
            default: ;
        endcase
        m_pc = m_pc + 16'(len);
        pend_ram  = sv_en && (sa < 16'h0200);
        pend_rom  = sv_en && (sa[15:12] == 4'hF);
        pend_addr = sa;
        pend_val  = sv;
        next_fetch = cnt + cy;
    endtask

    always @(negedge ph1) begin
        if (!model_on || !resetb) begin
            m_pc = {mrom[4093], mrom[4092]};
            m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_s = 8'hFD;
            m_c = 1'b0; m_n = 1'b0; m_z = 1'b0;
            cnt = -1; next_fetch = 2;
            pend_ram = 1'b0; pend_rom = 1'b0;
        end else begin
            cnt++;
            if (cnt == next_fetch) begin
                chk("fetch_state", 64'(dut.r_state), 64'(FETCH));
                chk("regs", {dut.r_pc, dut.r_a, dut.r_x, dut.r_y, dut.r_s, dut.r_c, dut.r_n, dut.r_z},
                    {m_pc, m_a, m_x, m_y, m_s, m_c, m_n, m_z});
                if (pend_ram)
                    chk("ram_store", dut.mem.RAM[pend_addr[8:0]], pend_val);
                if (pend_rom)
                    chk("rom_intact", dut.mem.ROM[pend_addr[11:0]], mrom[pend_addr[11:0]]);
                model_step();
            end
        end
    end

    // ---------------- random program generator ----------------
    task automatic gen_prog();
        int          r;
        logic [7:0]  op;
        logic [15:0] a;
        fill_rom();
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 22);
            if (r == 22) begin
                op = 8'($urandom_range(1, 255));
                if (listed(op)) op = 8'h02;
            end else begin
                op = ops[r];
            end
            put(op);
            case (op)
                8'hA9, 8'hA2, 8'hA0, 8'h85, 8'h86, 8'h84: put(8'($urandom_range(0, 255)));
                8'h8D, 8'h8E, 8'h8C: begin
                    case ($urandom_range(0, 5))
                        0:       a = 16'hF000 | 16'($urandom_range(0, 4095));
                        1:       a = 16'($urandom_range(16'h0200, 16'hEFFF));
                        default: a = 16'($urandom_range(0, 511));
                    endcase
                    put(a[7:0]); put(a[15:8]);
                end
                default: ;
            endcase
        end
        put_jmp_self();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Vector fetch + zero-page store
        load('{8'hA9, 8'h33, 8'h85, 8'h40});
        reset_cpu(1'b0);
        run(8);
        chk("vec_store", dut.mem.RAM[64], 8'h33);

        // Transfer chain
        load('{8'hA9, 8'h12, 8'hAA, 8'hE8, 8'h8A, 8'hA8, 8'hC8, 8'h98, 8'h85, 8'h41});
        reset_cpu(1'b0);
        run(25);
        chk("chain_ram41", dut.mem.RAM[9'h041], 8'h14);
        chk("chain_axy", {dut.r_a, dut.r_x, dut.r_y}, {8'h14, 8'h13, 8'h14});

        // Wrap and flags
        load('{8'hA2, 8'hFF, 8'hE8, 8'hA0, 8'h00, 8'h88});
        reset_cpu(1'b0);
        run(6);
        chk("inx_wrap", {dut.r_x, dut.r_z, dut.r_n}, {8'h00, 1'b1, 1'b0});
        run(4);
        chk("dey_wrap", {dut.r_y, dut.r_n, dut.r_z}, {8'hFF, 1'b1, 1'b0});

        // Stack transfers
        load('{8'hBA, 8'hA2, 8'h80, 8'h9A, 8'hA2, 8'h00, 8'hBA, 8'h8E, 8'h50, 8'h01});
        reset_cpu(1'b0);
        run(4);
        chk("tsx_reset", dut.r_x, 8'hFD);
        run(18);
        chk("stack_ram150", dut.mem.RAM[9'h150], 8'h80);
        chk("stack_sx", {dut.r_s, dut.r_x}, {8'h80, 8'h80});

        // ROM write ignored; also leaves a known byte at 0x0123
        load('{8'hA9, 8'h77, 8'h8D, 8'h00, 8'hF0, 8'h8D, 8'h23, 8'h01});
        reset_cpu(1'b0);
        run(20);
        chk("rom_unchanged", dut.mem.ROM[0], 8'hA9);
        chk("ram123_pre", dut.mem.RAM[9'h123], 8'h77);

        // Reset landing on the EXEC cycle of an absolute store
        load('{8'hA9, 8'h55, 8'h8D, 8'h23, 8'h01});
        reset_cpu(1'b0);
        run(7);
        resetb = 1'b0;
        run(1);
        chk("rst_abort_ram", dut.mem.RAM[9'h123], 8'h77);
        chk("rst_abort_state", 64'(dut.r_state), 64'(VEC_LO));
        resetb = 1'b1;
        run(2);
        chk("revector", {dut.r_pc, 8'(dut.r_state)}, {16'hF000, 8'(FETCH)});
        run(6);
        chk("rerun_store", dut.mem.RAM[9'h123], 8'h55);

        // Opcode 00 followed by STA $40 (RAM[0x40] holds 33 from the first program)
        load('{8'hA9, 8'h5A, 8'h00, 8'h85, 8'h40});
        reset_cpu(1'b0);
        run(20);
`ifdef BRK_HALT_EN
        chk("halt_ram40", dut.mem.RAM[9'h040], 8'h33);
        chk("halt_state_pc", {dut.r_pc, 8'(dut.r_state)}, {16'hF003, 8'(HALT)});
`else
        chk("brk_nop_ram40", dut.mem.RAM[9'h040], 8'h5A);
`endif

        // Random programs against the model
        for (int t = 0; t < 20; t++) begin
            gen_prog();
            reset_cpu(1'b1);
            run(250);
            chk("progress", m_pc, term);
            model_on = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
